// File: rtl/wb_regfile.sv
// ============================================================================
// Module   : wb_regfile
// Purpose  : Writeback-stage value select plus 16 x 16-bit register file
//            with two combinational read ports and same-cycle write bypass.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module wb_regfile #(
    parameter logic [3:0] LINK_REG = 4'd15,
    parameter bit         ZERO_R0  = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_wen,
    input  logic [3:0]  reg_waddr,
    input  logic [15:0] mem_rdata,
    input  logic [15:0] alu_result,
    input  logic        mem_to_reg,
    input  logic        jal,
    input  logic [15:0] next_pc,
    input  logic [3:0]  raddr_a,
    input  logic [3:0]  raddr_b,
    output logic [15:0] rdata_a,
    output logic [15:0] rdata_b,
    output logic        wb_wen,
    output logic [3:0]  wb_waddr,
    output logic [15:0] wb_data,
    output logic [15:0] wr_count
);

    localparam int c_NREGS = 16;

    logic [15:0] rf_word [c_NREGS];
    logic [15:0] wr_count_q;
    logic [15:0] wr_count_d;
    logic        r0_blocked;

    // ------------------------------------------------------------------
    // Writeback selection; JAL overrides both the source and destination
    // ------------------------------------------------------------------
    always_comb begin
        wb_data    = alu_result;
        wb_waddr   = reg_waddr;
        r0_blocked = 1'b0;
        if (jal) begin
            wb_data  = next_pc;
            wb_waddr = LINK_REG;
        end else if (mem_to_reg) begin
            wb_data  = mem_rdata;
        end
        r0_blocked = ZERO_R0 && (wb_waddr == 4'd0);
        wb_wen     = reg_wen && !r0_blocked;
    end

    // ------------------------------------------------------------------
    // Register storage; a hardwired-zero r0 needs no flops at all
    // ------------------------------------------------------------------
    for (genvar i = 0; i < c_NREGS; i++) begin : g_reg
        if (ZERO_R0 && (i == 0)) begin : g_zero
            assign rf_word[i] = 16'h0000;
        end else begin : g_flop
            logic [15:0] row_q;
            logic [15:0] row_d;

            always_comb begin
                row_d = row_q;
                if (wb_wen && (wb_waddr == 4'(i))) begin
                    row_d = wb_data;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    row_q <= 16'h0000;
                end else begin
                    row_q <= row_d;
                end
            end

            assign rf_word[i] = row_q;
        end
    end

    // ------------------------------------------------------------------
    // Read ports: the bypass gives zero-cycle write-to-read latency
    // ------------------------------------------------------------------
    always_comb begin
        rdata_a = rf_word[raddr_a];
        if (ZERO_R0 && (raddr_a == 4'd0)) begin
            rdata_a = 16'h0000;
        end else if (wb_wen && (raddr_a == wb_waddr)) begin
            rdata_a = wb_data;
        end
    end

    always_comb begin
        rdata_b = rf_word[raddr_b];
        if (ZERO_R0 && (raddr_b == 4'd0)) begin
            rdata_b = 16'h0000;
        end else if (wb_wen && (raddr_b == wb_waddr)) begin
            rdata_b = wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Retired-write counter, wraps naturally at 16 bits
    // ------------------------------------------------------------------
    always_comb begin
        wr_count_d = wr_count_q;
        if (wb_wen) begin
            wr_count_d = wr_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_count_q <= 16'h0000;
        end else begin
            wr_count_q <= wr_count_d;
        end
    end

    assign wr_count = wr_count_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile.sv
// ============================================================================
// Module   : tb_wb_regfile
// Purpose  : Scoreboard bench for wb_regfile, both r0 variants side by side.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        reg_wen;
    logic [3:0]  reg_waddr;
    logic [15:0] mem_rdata;
    logic [15:0] alu_result;
    logic        mem_to_reg;
    logic        jal;
    logic [15:0] next_pc;
    logic [3:0]  raddr_a;
    logic [3:0]  raddr_b;

    logic [15:0] ra0, rb0, wd0, cnt0;
    logic [15:0] ra1, rb1, wd1, cnt1;
    logic        we0, we1;
    logic [3:0]  wa0, wa1;

    wb_regfile #(.LINK_REG(4'd15), .ZERO_R0(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .reg_wen(reg_wen), .reg_waddr(reg_waddr),
        .mem_rdata(mem_rdata), .alu_result(alu_result), .mem_to_reg(mem_to_reg),
        .jal(jal), .next_pc(next_pc), .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(ra0), .rdata_b(rb0), .wb_wen(we0), .wb_waddr(wa0),
        .wb_data(wd0), .wr_count(cnt0)
    );

    wb_regfile #(.LINK_REG(4'd15), .ZERO_R0(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .reg_wen(reg_wen), .reg_waddr(reg_waddr),
        .mem_rdata(mem_rdata), .alu_result(alu_result), .mem_to_reg(mem_to_reg),
        .jal(jal), .next_pc(next_pc), .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(ra1), .rdata_b(rb1), .wb_wen(we1), .wb_waddr(wa1),
        .wb_data(wd1), .wr_count(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] ra   [2];
        logic [15:0] rb   [2];
        logic [15:0] cnt  [2];
        logic        wen  [2];
        logic [3:0]  waddr;
        logic [15:0] data;
    } exp_t;

    exp_t        sb [$];
    int          vectors     = 0;
    int          miscompares = 0;
    bit          nrst_val    = 1'b0;

    // Reference state: architectural view of each variant's register file
    logic [15:0] m_regs [2][16];
    logic [15:0] m_cnt  [2];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, " d0.rdata_a"},  ra0,              e.ra[0]);
            chk({e.tag, " d0.rdata_b"},  rb0,              e.rb[0]);
            chk({e.tag, " d0.wr_count"}, cnt0,             e.cnt[0]);
            chk({e.tag, " d0.wb_wen"},   {15'd0, we0},     {15'd0, e.wen[0]});
            chk({e.tag, " d0.wb_waddr"}, {12'd0, wa0},     {12'd0, e.waddr});
            chk({e.tag, " d0.wb_data"},  wd0,              e.data);
            chk({e.tag, " d1.rdata_a"},  ra1,              e.ra[1]);
            chk({e.tag, " d1.rdata_b"},  rb1,              e.rb[1]);
            chk({e.tag, " d1.wr_count"}, cnt1,             e.cnt[1]);
            chk({e.tag, " d1.wb_wen"},   {15'd0, we1},     {15'd0, e.wen[1]});
            chk({e.tag, " d1.wb_waddr"}, {12'd0, wa1},     {12'd0, e.waddr});
            chk({e.tag, " d1.wb_data"},  wd1,              e.data);
        end
    end

    task automatic step(input bit wen, input logic [3:0] wa, input logic [15:0] alu,
                        input logic [15:0] mem, input bit m2r, input bit j,
                        input logic [15:0] pc, input logic [3:0] a, input logic [3:0] b,
                        input bit check, input string tag);
        exp_t        e;
        logic [15:0] data;
        logic [3:0]  dest;
        bit          ew;
        @(posedge clk);
        #1;
        rst        = nrst_val;
        reg_wen    = wen;
        reg_waddr  = wa;
        alu_result = alu;
        mem_rdata  = mem;
        mem_to_reg = m2r;
        jal        = j;
        next_pc    = pc;
        raddr_a    = a;
        raddr_b    = b;
        if (!nrst_val) begin
            for (int d = 0; d < 2; d++) begin
                for (int r = 0; r < 16; r++) m_regs[d][r] = 16'h0000;
                m_cnt[d] = 16'h0000;
            end
        end
        data = j ? pc : (m2r ? mem : alu);
        dest = j ? 4'd15 : wa;
        e.tag   = tag;
        e.data  = data;
        e.waddr = dest;
        for (int d = 0; d < 2; d++) begin
            ew = wen && !(d == 1 && dest == 4'd0);
            e.wen[d] = ew;
            e.cnt[d] = m_cnt[d];
            if (d == 1 && a == 4'd0)     e.ra[d] = 16'h0000;
            else if (ew && a == dest)    e.ra[d] = data;
            else                         e.ra[d] = m_regs[d][a];
            if (d == 1 && b == 4'd0)     e.rb[d] = 16'h0000;
            else if (ew && b == dest)    e.rb[d] = data;
            else                         e.rb[d] = m_regs[d][b];
            if (nrst_val && ew) begin
                m_regs[d][dest] = data;
                m_cnt[d]        = m_cnt[d] + 16'd1;
            end
        end
        if (check) sb.push_back(e);
    endtask

    task automatic rd(input logic [3:0] a, input logic [3:0] b, input string tag);
        step(1'b0, 4'd7, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'h0, a, b, 1'b1, tag);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  wa, a, b;
        logic [15:0] v;
        rst = 1'b0; reg_wen = 1'b0; reg_waddr = 4'd0; mem_rdata = 16'h0;
        alu_result = 16'h0; mem_to_reg = 1'b0; jal = 1'b0; next_pc = 16'h0;
        raddr_a = 4'd0; raddr_b = 4'd0;
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 16; r++) m_regs[d][r] = 16'h0000;
            m_cnt[d] = 16'h0000;
        end
        nrst_val = 1'b0;
        rd(4'd3, 4'd9, "reset");
        nrst_val = 1'b1;
        rd(4'd0, 4'd15, "post_reset");

        // ALU write with same-cycle bypass on both ports
        step(1'b1, 4'd3, 16'h1234, 16'h0, 1'b0, 1'b0, 16'h0, 4'd3, 4'd3, 1'b1, "alu_wr");
        rd(4'd3, 4'd1, "alu_rd");

        // Load then JAL; JAL must go to r15 and leave r2 alone
        step(1'b1, 4'd5, 16'h1111, 16'hBEEF, 1'b1, 1'b0, 16'h0, 4'd5, 4'd2, 1'b1, "load_wr");
        step(1'b1, 4'd2, 16'h2222, 16'h3333, 1'b1, 1'b1, 16'h0042, 4'd15, 4'd2, 1'b1, "jal_wr");
        rd(4'd5, 4'd15, "jal_rd");
        rd(4'd2, 4'd3, "jal_r2");
        step(1'b0, 4'd2, 16'h2222, 16'h3333, 1'b0, 1'b1, 16'h0077, 4'd15, 4'd2, 1'b1, "jal_nowen");

        // Disabled write must neither bypass nor commit
        step(1'b1, 4'd7, 16'h5555, 16'h0, 1'b0, 1'b0, 16'h0, 4'd7, 4'd0, 1'b1, "r7_wr");
        step(1'b0, 4'd7, 16'hFFFF, 16'h0, 1'b0, 1'b0, 16'h0, 4'd7, 4'd7, 1'b1, "r7_dis");
        rd(4'd7, 4'd7, "r7_rd");

        // r0 write: ordinary on variant 0, discarded on variant 1
        step(1'b1, 4'd0, 16'hAAAA, 16'h0, 1'b0, 1'b0, 16'h0, 4'd0, 4'd0, 1'b1, "r0_wr");
        rd(4'd0, 4'd5, "r0_rd");

        // Asynchronous reset mid-run, then a bypassed write that must not commit
        nrst_val = 1'b0;
        rd(4'd3, 4'd5, "mid_reset");
        step(1'b1, 4'd4, 16'h4444, 16'h0, 1'b0, 1'b0, 16'h0, 4'd4, 4'd4, 1'b1, "rst_bypass");
        nrst_val = 1'b1;
        step(1'b1, 4'd6, 16'h6666, 16'h0, 1'b0, 1'b0, 16'h0, 4'd4, 4'd6, 1'b1, "first_edge");
        rd(4'd4, 4'd6, "after_rst");

        for (int n = 0; n < 1500; n++) begin
            wa = 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
            b  = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
            step(($urandom_range(0, 3) != 0), wa, 16'($urandom), 16'($urandom),
                 1'($urandom), ($urandom_range(0, 7) == 0), 16'($urandom), a, b,
                 1'b1, "rand");
        end

        // Counter wrap: 65535 commits, then one more
        nrst_val = 1'b0;
        rd(4'd1, 4'd2, "wrap_reset");
        nrst_val = 1'b1;
        for (int n = 0; n < 65535; n++) begin
            wa = 4'($urandom_range(1, 14));
            step(1'b1, wa, 16'($urandom), 16'h0, 1'b0, 1'b0, 16'h0, wa, 4'd0, 1'b0, "preload");
        end
        v = 16'($urandom);
        step(1'b1, 4'd9, v, 16'h0, 1'b0, 1'b0, 16'h0, 4'd9, 4'd9, 1'b1, "wrap_ffff");
        rd(4'd9, 4'd9, "wrap_0000");

        repeat (3) @(posedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
